conv_frame_ctrl: RTL and testbench

Frame-level sequencer for the greyscale+convolution image path. It detects frame start/end from the camera pixel stream and applies filter-direction changes (vertical/horizontal) only at frame boundaries, with an optional per-frame auto-alternate mode. It also masks the convolution's valid output during line-buffer warm-up rows and columns and counts processed frames. It sits beside the image-processing block: it drives that block's direction select and gates its valid output.

---
 rtl/conv_ctrl_pkg.sv | 13 +
 rtl/conv_frame_ctrl_if.sv | 29 ++
 rtl/sync2.sv | 22 ++
 rtl/conv_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_conv_frame_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the convolution frame controller.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    BLANK
  } frame_state_t;

  localparam logic MODE_VERT = 1'b0;
  localparam logic MODE_HORZ = 1'b1;

endpackage

// File: rtl/conv_frame_ctrl_if.sv
// Pixel-stream, control and status bundle between the image path and conv_frame_ctrl.
interface conv_frame_ctrl_if #(
  parameter int unsigned FCNT_W = 16
);
  logic [10:0]       iX_Cont;
  logic [10:0]       iY_Cont;
  logic              iDVAL;
  logic              iSW_REQ;
  logic              iAUTO;
  logic              iPROC_VALID;
  logic              oSWITCH;
  logic              oVALID;
  logic              oSOF;
  logic              oEOF;
  logic [FCNT_W-1:0] oFRAME_CNT;
  logic              oPENDING;
  logic [21:0]       oLAST_PIX;
  logic              oFRAME_ERR;

  modport master (
    output iX_Cont, iY_Cont, iDVAL, iSW_REQ, iAUTO, iPROC_VALID,
    input  oSWITCH, oVALID, oSOF, oEOF, oFRAME_CNT, oPENDING, oLAST_PIX, oFRAME_ERR
  );

  modport slave (
    input  iX_Cont, iY_Cont, iDVAL, iSW_REQ, iAUTO, iPROC_VALID,
    output oSWITCH, oVALID, oSOF, oEOF, oFRAME_CNT, oPENDING, oLAST_PIX, oFRAME_ERR
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for slow asynchronous board inputs.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: frame-aligned direction switching, warm-up valid masking, frame count.
// Optional FRAME_STATS_EN adds per-frame pixel count and short/long frame flag.
module conv_frame_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W        = 640,
  parameter int unsigned IMG_H        = 480,
  parameter int unsigned WARMUP_LINES = 2,
  parameter int unsigned WARMUP_COLS  = 2,
  parameter int unsigned FCNT_W       = 16
) (
  input logic              iCLK,
  input logic              iRST,
  conv_frame_ctrl_if.slave bus
);
  localparam logic [10:0] XLast    = 11'(IMG_W - 1);
  localparam logic [10:0] YLast    = 11'(IMG_H - 1);
  localparam logic [10:0] WarmRows = 11'(WARMUP_LINES);
  localparam logic [10:0] WarmCols = 11'(WARMUP_COLS);

  logic sw_s;
  logic auto_s;

  sync2 u_sync_sw (
    .clk_i (iCLK),
    .rst_i (iRST),
    .d_i   (bus.iSW_REQ),
    .q_o   (sw_s)
  );

  sync2 u_sync_auto (
    .clk_i (iCLK),
    .rst_i (iRST),
    .d_i   (bus.iAUTO),
    .q_o   (auto_s)
  );

  logic sof_evt;
  logic eof_evt;
  assign sof_evt = bus.iDVAL && (bus.iX_Cont == '0) && (bus.iY_Cont == '0);
  assign eof_evt = bus.iDVAL && (bus.iX_Cont == XLast) && (bus.iY_Cont == YLast);

  frame_state_t      state_q, state_d;
  logic              switch_q, switch_d;
  logic              pending_q, pending_d;
  logic              valid_q, valid_d;
  logic              sof_q, eof_q;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [10:0]       ox_q, ox_d;
  logic [10:0]       oy_q, oy_d;

  // A SOF while ACTIVE means the EOF was missed: stay ACTIVE and start a new frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, BLANK: if (sof_evt) state_d = ACTIVE;
      ACTIVE:      if (!sof_evt && eof_evt) state_d = BLANK;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    switch_d = switch_q;
    fcnt_d   = fcnt_q;
    if (sof_evt) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
      if (auto_s) switch_d = (switch_q == MODE_HORZ) ? MODE_VERT : MODE_HORZ;
      else        switch_d = sw_s;
    end
    pending_d = (sw_s != switch_q) && !auto_s;
  end

  // Mask counters follow the delayed convolution output, so SOF must not clear them.
  always_comb begin
    ox_d = ox_q;
    oy_d = oy_q;
    if (bus.iPROC_VALID) begin
      if (ox_q == XLast) begin
        ox_d = '0;
        oy_d = (oy_q == YLast) ? '0 : oy_q + 11'd1;
      end else begin
        ox_d = ox_q + 11'd1;
      end
    end
    valid_d = bus.iPROC_VALID && (oy_q >= WarmRows) && (ox_q >= WarmCols) && (state_q != IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= IDLE;
      switch_q  <= MODE_VERT;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      fcnt_q    <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
    end else begin
      state_q   <= state_d;
      switch_q  <= switch_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      sof_q     <= sof_evt;
      eof_q     <= eof_evt;
      fcnt_q    <= fcnt_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
    end
  end

  assign bus.oSWITCH    = switch_q;
  assign bus.oPENDING   = pending_q;
  assign bus.oVALID     = valid_q;
  assign bus.oSOF       = sof_q;
  assign bus.oEOF       = eof_q;
  assign bus.oFRAME_CNT = fcnt_q;

`ifdef FRAME_STATS_EN
  localparam logic [21:0] FramePix = 22'(IMG_W * IMG_H);

  logic [21:0] pix_cnt_q, pix_cnt_d;
  logic [21:0] last_pix_q, last_pix_d;
  logic        frame_err_q, frame_err_d;

  // On a missed EOF the SOF pixel belongs to the new frame; on EOF the EOF pixel is included.
  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    last_pix_d  = last_pix_q;
    frame_err_d = frame_err_q;
    if (sof_evt) begin
      pix_cnt_d = 22'd1;
      if (state_q == ACTIVE) begin
        last_pix_d  = pix_cnt_q;
        frame_err_d = (pix_cnt_q != FramePix);
      end
    end else if ((state_q == ACTIVE) && bus.iDVAL) begin
      pix_cnt_d = pix_cnt_q + 22'd1;
      if (eof_evt) begin
        last_pix_d  = pix_cnt_q + 22'd1;
        frame_err_d = ((pix_cnt_q + 22'd1) != FramePix);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pix_cnt_q   <= '0;
      last_pix_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      last_pix_q  <= last_pix_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.oLAST_PIX  = last_pix_q;
  assign bus.oFRAME_ERR = frame_err_q;
`else
  assign bus.oLAST_PIX  = '0;
  assign bus.oFRAME_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl on a small 8x6 frame.
module tb_conv_frame_ctrl;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WL = 2;
  localparam int WC = 2;
  localparam int FW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_frame_ctrl_if #(.FCNT_W(FW)) bus ();

  conv_frame_ctrl #(
    .IMG_W        (W),
    .IMG_H        (H),
    .WARMUP_LINES (WL),
    .WARMUP_COLS  (WC),
    .FCNT_W       (FW)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic v;
    logic sof;
    logic eof;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_ox, m_oy, exp_fcnt;
  bit   m_started;
  int   sof_seen, eof_seen, valid_high;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input cycle: push the expected registered response, clock, then pop and compare.
  task automatic drive_cycle(input int x, input int y, input bit dv, input bit pv);
    exp_t e;
    bus.iX_Cont     = 11'(x);
    bus.iY_Cont     = 11'(y);
    bus.iDVAL       = dv;
    bus.iPROC_VALID = pv;
    e.sof = dv && (x == 0) && (y == 0);
    e.eof = dv && (x == W - 1) && (y == H - 1);
    e.v   = pv && m_started && (m_oy >= WL) && (m_ox >= WC);
    exp_q.push_back(e);
    if (pv) begin
      if (m_ox == W - 1) begin
        m_ox = 0;
        m_oy = (m_oy == H - 1) ? 0 : m_oy + 1;
      end else begin
        m_ox = m_ox + 1;
      end
    end
    if (e.sof) begin
      m_started = 1'b1;
      exp_fcnt  = exp_fcnt + 1;
    end
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (bus.oVALID !== e.v) begin
      n_fail++;
      $display("FAIL oVALID at x=%0d y=%0d: got %b want %b", x, y, bus.oVALID, e.v);
    end
    n_checks++;
    if (bus.oSOF !== e.sof) begin
      n_fail++;
      $display("FAIL oSOF at x=%0d y=%0d: got %b want %b", x, y, bus.oSOF, e.sof);
    end
    n_checks++;
    if (bus.oEOF !== e.eof) begin
      n_fail++;
      $display("FAIL oEOF at x=%0d y=%0d: got %b want %b", x, y, bus.oEOF, e.eof);
    end
    if (bus.oSOF === 1'b1) sof_seen++;
    if (bus.oEOF === 1'b1) eof_seen++;
    if (bus.oVALID === 1'b1) valid_high++;
  endtask

  task automatic send_range(input int first, input int last, input bit pv);
    for (int p = first; p <= last; p++) drive_cycle(p % W, p / W, 1'b1, pv);
  endtask

  task automatic idle_cycles(input int n, input bit pv);
    for (int i = 0; i < n; i++) drive_cycle(W - 1, 0, 1'b0, pv);
  endtask

  task automatic do_reset(input int cycles, input bit pv);
    bus.iDVAL       = 1'b0;
    bus.iPROC_VALID = pv;
    rst             = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    n_checks++;
    if ({bus.oSWITCH, bus.oVALID, bus.oSOF, bus.oEOF, bus.oPENDING, bus.oFRAME_ERR} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000",
               {bus.oSWITCH, bus.oVALID, bus.oSOF, bus.oEOF, bus.oPENDING, bus.oFRAME_ERR});
    end
    n_checks++;
    if (bus.oFRAME_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_fcnt: got %0d want 0", bus.oFRAME_CNT);
    end
    n_checks++;
    if (bus.oLAST_PIX !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_last_pix: got %0d want 0", bus.oLAST_PIX);
    end
    rst             = 1'b0;
    bus.iPROC_VALID = 1'b0;
    m_ox      = 0;
    m_oy      = 0;
    m_started = 1'b0;
    exp_fcnt  = 0;
  endtask

  task automatic test_reset();
    do_reset(2, 1'b0);
  endtask

  task automatic test_frame_vert();
    int e_last;
    bus.iSW_REQ = 1'b0;
    bus.iAUTO   = 1'b0;
    idle_cycles(3, 1'b0);
    sof_seen = 0;
    eof_seen = 0;
    send_range(0, W * H - 1, 1'b0);
    idle_cycles(2, 1'b0);
    n_checks++;
    if (bus.oSWITCH !== 1'b0) begin
      n_fail++;
      $display("FAIL vert_switch: got %b want 0", bus.oSWITCH);
    end
    n_checks++;
    if (bus.oFRAME_CNT !== 16'(exp_fcnt) || exp_fcnt != 1) begin
      n_fail++;
      $display("FAIL vert_fcnt: got %0d want 1", bus.oFRAME_CNT);
    end
    n_checks++;
    if (sof_seen != 1 || eof_seen != 1) begin
      n_fail++;
      $display("FAIL vert_pulses: got sof=%0d eof=%0d want 1 1", sof_seen, eof_seen);
    end
`ifdef FRAME_STATS_EN
    e_last = W * H;
`else
    e_last = 0;
`endif
    n_checks++;
    if (bus.oLAST_PIX !== 22'(e_last) || bus.oFRAME_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL vert_stats: got last=%0d err=%b want last=%0d err=0",
               bus.oLAST_PIX, bus.oFRAME_ERR, e_last);
    end
  endtask

  // Runs in BLANK, so any high oVALID also shows the FSM left IDLE.
  task automatic test_valid_mask();
    valid_high = 0;
    idle_cycles(W * H, 1'b1);
    idle_cycles(1, 1'b0);
    n_checks++;
    if (valid_high != (W - WC) * (H - WL)) begin
      n_fail++;
      $display("FAIL mask_count: got %0d want %0d", valid_high, (W - WC) * (H - WL));
    end
  endtask

  task automatic test_switch_pending();
    send_range(0, 19, 1'b0);
    bus.iSW_REQ = 1'b1;
    send_range(20, 22, 1'b0);
    n_checks++;
    if (bus.oPENDING !== 1'b1 || bus.oSWITCH !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_rise: got pend=%b sw=%b want pend=1 sw=0", bus.oPENDING, bus.oSWITCH);
    end
    send_range(23, W * H - 1, 1'b0);
    idle_cycles(3, 1'b0);
    n_checks++;
    if (bus.oSWITCH !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_hold: got sw=%b want 0", bus.oSWITCH);
    end
    drive_cycle(0, 0, 1'b1, 1'b0);
    n_checks++;
    if (bus.oSWITCH !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_apply: got sw=%b want 1", bus.oSWITCH);
    end
    send_range(1, 2, 1'b0);
    n_checks++;
    if (bus.oPENDING !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_clear: got %b want 0", bus.oPENDING);
    end
    send_range(3, W * H - 1, 1'b0);
    idle_cycles(2, 1'b0);
  endtask

  task automatic test_auto();
    bit want;
    do_reset(1, 1'b0);
    bus.iSW_REQ = 1'b0;
    bus.iAUTO   = 1'b1;
    idle_cycles(3, 1'b0);
    for (int f = 0; f < 4; f++) begin
      want = (f % 2 == 0);
      n_checks++;
      if (bus.oSWITCH !== !want) begin
        n_fail++;
        $display("FAIL auto_pre f=%0d: got %b want %b", f, bus.oSWITCH, !want);
      end
      drive_cycle(0, 0, 1'b1, 1'b0);
      n_checks++;
      if (bus.oSWITCH !== want) begin
        n_fail++;
        $display("FAIL auto_post f=%0d: got %b want %b", f, bus.oSWITCH, want);
      end
      send_range(1, W * H - 1, 1'b0);
      idle_cycles(2, 1'b0);
      n_checks++;
      if (bus.oSWITCH !== want) begin
        n_fail++;
        $display("FAIL auto_hold f=%0d: got %b want %b", f, bus.oSWITCH, want);
      end
    end
    n_checks++;
    if (bus.oFRAME_CNT !== 16'd4 || bus.oPENDING !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_fcnt: got cnt=%0d pend=%b want cnt=4 pend=0", bus.oFRAME_CNT, bus.oPENDING);
    end
  endtask

  task automatic test_double_sof();
    int e_last1, e_last2;
    bit e_err1;
    bus.iAUTO   = 1'b0;
    bus.iSW_REQ = 1'b0;
    idle_cycles(3, 1'b0);
    send_range(0, 3 * W + 4, 1'b0);
    drive_cycle(0, 0, 1'b1, 1'b0);
`ifdef FRAME_STATS_EN
    e_last1 = 3 * W + 5;
    e_err1  = 1'b1;
    e_last2 = W * H;
`else
    e_last1 = 0;
    e_err1  = 1'b0;
    e_last2 = 0;
`endif
    n_checks++;
    if (bus.oFRAME_CNT !== 16'(exp_fcnt) || exp_fcnt != 6) begin
      n_fail++;
      $display("FAIL dsof_fcnt: got %0d want 6", bus.oFRAME_CNT);
    end
    n_checks++;
    if (bus.oLAST_PIX !== 22'(e_last1) || bus.oFRAME_ERR !== e_err1) begin
      n_fail++;
      $display("FAIL dsof_stats: got last=%0d err=%b want last=%0d err=%b",
               bus.oLAST_PIX, bus.oFRAME_ERR, e_last1, e_err1);
    end
    eof_seen = 0;
    send_range(1, W * H - 1, 1'b0);
    idle_cycles(2, 1'b0);
    n_checks++;
    if (bus.oLAST_PIX !== 22'(e_last2) || bus.oFRAME_ERR !== 1'b0 || eof_seen != 1) begin
      n_fail++;
      $display("FAIL dsof_full: got last=%0d err=%b eof=%0d want last=%0d err=0 eof=1",
               bus.oLAST_PIX, bus.oFRAME_ERR, eof_seen, e_last2);
    end
  endtask

  task automatic test_mid_reset();
    bus.iSW_REQ = 1'b1;
    idle_cycles(3, 1'b0);
    send_range(0, 2 * W + 3, 1'b0);
    n_checks++;
    if (bus.oSWITCH !== 1'b1) begin
      n_fail++;
      $display("FAIL mrst_pre: got sw=%b want 1", bus.oSWITCH);
    end
    do_reset(1, 1'b1);
    valid_high = 0;
    idle_cycles(20, 1'b1);
    n_checks++;
    if (valid_high != 0) begin
      n_fail++;
      $display("FAIL mrst_idle_valid: got %0d highs want 0", valid_high);
    end
    send_range(0, W * H - 1, 1'b1);
    n_checks++;
    if (bus.oFRAME_CNT !== 16'd1 || bus.oSWITCH !== 1'b1) begin
      n_fail++;
      $display("FAIL mrst_restart: got cnt=%0d sw=%b want cnt=1 sw=1", bus.oFRAME_CNT, bus.oSWITCH);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.iX_Cont     = '0;
    bus.iY_Cont     = '0;
    bus.iDVAL       = 1'b0;
    bus.iSW_REQ     = 1'b0;
    bus.iAUTO       = 1'b0;
    bus.iPROC_VALID = 1'b0;
    test_reset();
    test_frame_vert();
    test_valid_mask();
    test_switch_pending();
    test_auto();
    test_double_sof();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
